// File: rtl/serial_word_tx_pkg.sv
// rtl/serial_word_tx_pkg.sv - shared state encoding and default word width for serial_word_tx
package serial_word_tx_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/bit_counter.sv
// rtl/bit_counter.sv - mod-MOD counter with synchronous clear, enable and terminal-count flag
module bit_counter #(
    parameter  int MOD = 8,
    localparam int CW  = (MOD > 1) ? $clog2(MOD) : 1
) (
    input  logic          clk,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [CW-1:0] count_o,
    output logic          tc_o
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign tc_o    = (count_q == CW'(MOD - 1));
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = tc_o ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

endmodule

// File: rtl/serial_word_tx.sv
// rtl/serial_word_tx.sv - parallel-to-serial word transmitter, LSB first, with first/last bit markers
module serial_word_tx
    import serial_word_tx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             bit_first,
    output logic             bit_last
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] sh_d;
    logic [CW-1:0]    count;
    logic             tc;
    logic             accept;

    // Counter is held at zero while idle so a fresh word always starts at bit 0.
    bit_counter #(
        .MOD (WIDTH)
    ) u_bit_counter (
        .clk     (clk),
        .clr_i   (rst || (state_q == IDLE)),
        .en_i    (state_q == SHIFT),
        .count_o (count),
        .tc_o    (tc)
    );

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (tc && !accept) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            sh_d = data_in;
        end else if (state_q == SHIFT) begin
            sh_d = sh_q >> 1;
        end
    end

    // Serial outputs depend only on registered state; in_ready also folds in rst.
    always_comb begin
        in_ready  = 1'b0;
        bit_out   = 1'b0;
        bit_valid = 1'b0;
        bit_first = 1'b0;
        bit_last  = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = !rst;
            end
            SHIFT: begin
                bit_valid = 1'b1;
                bit_out   = sh_q[0];
                bit_first = (count == '0);
                bit_last  = tc;
                in_ready  = tc && !rst;
            end
            default: in_ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_serial_word_tx.sv
// tb/tb_serial_word_tx.sv - scoreboard bench for serial_word_tx, WIDTH=8 random plus WIDTH=1 directed
module tb_serial_word_tx;

    localparam int W = 8;

    typedef struct packed {
        logic b;
        logic f;
        logic l;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] data_in;
    logic         in_valid;
    logic         in_ready;
    logic         bit_out;
    logic         bit_valid;
    logic         bit_first;
    logic         bit_last;

    logic         rst1;
    logic [0:0]   data1;
    logic         valid1;
    logic         ready1;
    logic         out1;
    logic         bvalid1;
    logic         first1;
    logic         last1;

    exp_t q[$];
    int   rem = 0;
    int   passed = 0;
    int   total = 0;

    always #5 clk = ~clk;

    serial_word_tx #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .bit_first (bit_first),
        .bit_last  (bit_last)
    );

    serial_word_tx #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst       (rst1),
        .data_in   (data1),
        .in_valid  (valid1),
        .in_ready  (ready1),
        .bit_out   (out1),
        .bit_valid (bvalid1),
        .bit_first (first1),
        .bit_last  (last1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end else begin
            passed++;
        end
    endtask

    // Reference model: a word accepted at an edge contributes W bits, one per cycle,
    // and the producer may hand over a new word only while at most one bit remains.
    task automatic step(input logic v, input logic [W-1:0] d, input logic r);
        in_valid = v;
        data_in  = d;
        rst      = r;
        @(posedge clk);
        if (r) begin
            q.delete();
            rem = 0;
        end else if (v && rem <= 1) begin
            rem = W;
            for (int i = 0; i < W; i++) begin
                q.push_back('{b: d[i], f: (i == 0), l: (i == W - 1)});
            end
        end else if (rem > 0) begin
            rem--;
        end
        #2;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            chk("in_ready", {31'd0, in_ready}, {31'd0, (!rst && rem <= 1)});
            chk("bit_valid", {31'd0, bit_valid}, {31'd0, (q.size() != 0)});
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("bit_out", {31'd0, bit_out}, {31'd0, e.b});
                chk("bit_first", {31'd0, bit_first}, {31'd0, e.f});
                chk("bit_last", {31'd0, bit_last}, {31'd0, e.l});
            end else begin
                chk("idle_outputs", {29'd0, bit_out, bit_first, bit_last}, 32'd0);
            end
        end
    end

    initial begin
        logic [3:0] exp1 [3];
        logic       d1seq [3];
        exp1  = '{4'b1111, 4'b0111, 4'b1111};
        d1seq = '{1'b1, 1'b0, 1'b1};
        rst1   = 1'b1;
        valid1 = 1'b0;
        data1  = 1'b0;

        step(1'b0, '0, 1'b1);
        step(1'b1, 8'hFF, 1'b1);
        step(1'b0, '0, 1'b0);

        step(1'b1, 8'b01011100, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, W'($urandom), 1'b0);

        step(1'b1, 8'hA5, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 8'h3C, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, W'($urandom), 1'b0);

        step(1'b1, 8'hFF, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, W'($urandom), 1'b0);
        step(1'b1, 8'h77, 1'b1);
        step(1'b1, 8'h01, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, W'($urandom), 1'b0);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 2) != 0, W'($urandom), $urandom_range(0, 60) == 0);
        end
        for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b0);
        chk("drained", q.size(), 32'd0);

        @(posedge clk);
        #2;
        rst1   = 1'b0;
        valid1 = 1'b1;
        data1  = d1seq[0];
        @(negedge clk);
        chk("w1_ready_idle", {31'd0, ready1}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2;
            if (i < 2) data1 = d1seq[i + 1];
            else valid1 = 1'b0;
            @(negedge clk);
            chk("w1_bit", {28'd0, out1, first1, last1, bvalid1}, {28'd0, exp1[i]});
        end
        @(posedge clk);
        @(negedge clk);
        chk("w1_idle", {28'd0, out1, first1, last1, bvalid1}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/serial_word_tx.md
SERIAL_WORD_TX -- requirements
Module: serial_word_tx

Interface
REQ-001 Parameter WIDTH, default 8, meaning word length in bits (legal range 1..32).
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 data_in  input  WIDTH  parallel word to transmit; sampled only on an accept.
REQ-005 in_valid  input  1  producer has a word on data_in.
REQ-006 in_ready  output  1  block SHALL accept data_in on a clk edge where in_valid && in_ready.
REQ-007 bit_out  output  1  serial data, LSB first; drives bit_in of the serial two's complement block.
REQ-008 bit_valid  output  1  bit_out carries a word bit this cycle.
REQ-009 bit_first  output  1  high with bit 0 of each word; downstream uses it to clear its per-word state.
REQ-010 bit_last  output  1  high with bit WIDTH-1 of each word.

Function
REQ-011 The FSM SHALL have two states: IDLE (no word in flight) and SHIFT (word being sent).
REQ-012 in_ready SHALL be 1 in IDLE and SHALL equal bit_last in SHIFT; it SHALL be 0 while rst is high.
REQ-013 On an accept in IDLE, the FSM SHALL go to SHIFT, and the next cycle SHALL present data_in[0] with bit_valid=1 and bit_first=1 (latency: one cycle from accept edge to first bit).
REQ-014 In SHIFT, cycle k (k=0..WIDTH-1) after entry SHALL present bit k of the accepted word; a shift register SHALL shift right one place per cycle.
REQ-015 A bit counter SHALL count 0..WIDTH-1; bit_last SHALL be 1 when the count is WIDTH-1.
REQ-016 On the bit_last cycle with an accept, the FSM SHALL stay in SHIFT and present bit 0 of the new word on the next cycle with bit_first=1, leaving no idle gap.
REQ-017 On the bit_last cycle without an accept, the FSM SHALL return to IDLE; bit_valid, bit_first, bit_last and bit_out SHALL be 0 in IDLE.
REQ-018 If WIDTH=1, bit_first and bit_last SHALL both be 1 on the single bit cycle.
REQ-019 data_in changes while not accepting SHALL have no effect; in_valid without in_ready SHALL be ignored, with no data loss.
REQ-020 The outputs bit_out, bit_valid, bit_first and bit_last SHALL be registered, with no combinational path from inputs to them.

Reset
REQ-021 When rst is high at a clk edge, the FSM SHALL go to IDLE, the counter SHALL go to 0, and the shift register SHALL go to 0.
REQ-022 After that edge, bit_out, bit_valid, bit_first and bit_last SHALL be 0; in_ready SHALL be 0 while rst is high and 1 in the first cycle after rst falls.
REQ-023 Reset mid-word SHALL abandon the word; no remaining bits SHALL be emitted, and no accept SHALL occur in a cycle with rst high.

Structure
REQ-024 Shared package SHALL hold the state encoding (IDLE=0, SHIFT=1) and the default WIDTH constant.
REQ-025 One sub-module, bit_counter (mod-WIDTH counter with clear, enable and terminal-count output), SHALL be instantiated; the FSM and shift register SHALL stay in serial_word_tx.

Verification
REQ-026 Single word, WIDTH=8, data_in=8'b01011100 accepted at edge T -> bit_out over cycles T+1..T+8 = 0,0,1,1,1,0,1,0; bit_first at T+1 only; bit_last at T+8 only; IDLE at T+9.
REQ-027 Back-to-back words 8'hA5 then 8'h3C, with in_valid held -> 16 consecutive bit_valid cycles, second bit_first on the cycle right after the first bit_last, and bits 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0.
REQ-028 Backpressure: in_valid high during bits 1..6 of a word -> in_ready=0, no accept, word contents unaffected; accept occurs on the bit_last cycle.
REQ-029 Reset mid-word: rst high at the edge after bit 3 of 8'hFF -> next cycle all outputs 0 and state IDLE; new word 8'h01 then emits 1,0,0,0,0,0,0,0 cleanly.
REQ-030 Chain with the two's complement block, driving its rst from bit_first -> 8'b00011100 yields serial 0,0,1,0,0,1,1,1 (8'b11100100).
REQ-031 WIDTH=1 build, words 1,0,1 back-to-back -> bit_out 1,0,1 with bit_first=bit_last=1 each cycle.
